// File: rtl/ram_test_pkg.sv
// ----------------------------------------------------------------------------
// ram_test_pkg
// Shared definitions for the block-RAM self-test:
//   - default RAM geometry (ADDR_W_DEF, DATA_W_DEF)
//   - FSM state enum (IDLE, WRITE, READ, DONE)
//   - pattern(): the pass-dependent data word written and expected at an
//     address. The result is 32 bits wide; callers truncate it to DATA_W.
// ----------------------------------------------------------------------------
package ram_test_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The pass number sits in bits [15:8], so each pass writes different
    // data. This lets a read find stale contents left by the previous pass.
    function automatic logic [31:0] pattern(input logic [31:0] a,
                                            input logic [7:0]  pass_num);
        return a + {16'h0000, pass_num, 8'h00};
    endfunction

endpackage

// File: rtl/ram_sp.sv
// ----------------------------------------------------------------------------
// ram_sp
// Single-port synchronous RAM with a registered read in read-first mode.
// The array has no reset, so synthesis can infer block RAM.
//
// Parameters: ADDR_W (depth = 2**ADDR_W), DATA_W (word width)
// Ports:
//   clk  in           rising-edge clock
//   we   in           write enable
//   addr in  [ADDR_W] read/write address
//   din  in  [DATA_W] write data
//   dout out [DATA_W] read data, valid one cycle after addr is presented
// ----------------------------------------------------------------------------
module ram_sp #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Read-first: during a write cycle, dout returns the old contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_self_test.sv
// ----------------------------------------------------------------------------
// ram_self_test
// Free-running block-RAM exerciser. Each pass fills the RAM with
// pattern(addr), reads every word back, and compares it with the expected
// pattern. Status outputs can be probed with an ILA.
//
// Parameters:
//   ADDR_W   RAM address width (depth = 2**ADDR_W)
//   DATA_W   RAM word width
//   ERR_ADDR address whose written word gets bit 0 flipped when injection
//            is compiled in
// Ports:
//   clk       in       rising-edge clock
//   rst_n     in       asynchronous reset, active-high despite the name
//   test_done out      one-cycle pulse in the DONE cycle of each pass
//   test_err  out      sticky; set on the first mismatch
//   err_cnt   out [16] count of mismatching words, saturating
//   pass_cnt  out [8]  count of completed passes, wraps
// Configuration:
//   RAM_TEST_ERR_INJECT_EN  when defined, corrupts the word at ERR_ADDR on
//                           every pass, so each pass flags exactly one error.
// ----------------------------------------------------------------------------
module ram_self_test
    import ram_test_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ERR_ADDR = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        test_done,
    output logic        test_err,
    output logic [15:0] err_cnt,
    output logic [7:0]  pass_cnt
);

`ifdef RAM_TEST_ERR_INJECT_EN
    localparam logic INJECT_EN = 1'b1;
`else
    localparam logic INJECT_EN = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rd_addr_d;
    logic              rd_vld;
    logic              we;
    logic              last_addr;
    logic              mismatch;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] dout;

    assign we        = (state == WRITE);
    assign last_addr = &addr;

    // Write data. When injection is not compiled in, INJECT_EN is a
    // constant 0, so the flip is optimised away.
    always_comb begin
        wr_data    = DATA_W'(pattern(32'(addr), pass_cnt));
        wr_data[0] = wr_data[0] ^ (INJECT_EN & (addr == ADDR_W'(ERR_ADDR)));
    end

    // pass_cnt only changes in DONE, after the last compare, so the
    // expected data here matches what this pass wrote.
    assign exp_data = DATA_W'(pattern(32'(rd_addr_d), pass_cnt));
    assign mismatch = rd_vld && (dout != exp_data);

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (we),
        .addr (addr),
        .din  (wr_data),
        .dout (dout)
    );

    // Sequencer: IDLE -> WRITE (one full sweep) -> READ (one full sweep)
    // -> DONE. test_done is raised on the last READ edge, so the registered
    // pulse lines up with the DONE cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            test_done <= 1'b0;
            pass_cnt  <= 8'd0;
        end else begin
            test_done <= 1'b0;
            case (state)
                IDLE: begin
                    addr  <= '0;
                    state <= WRITE;
                end
                WRITE: begin
                    addr <= addr + ADDR_W'(1);
                    if (last_addr) begin
                        state <= READ;
                    end
                end
                READ: begin
                    addr <= addr + ADDR_W'(1);
                    if (last_addr) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                    end
                end
                DONE: begin
                    pass_cnt <= pass_cnt + 8'd1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Checker. The RAM output is one cycle behind the issued address, so
    // the read-valid flag and the address are delayed to line up with dout.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_vld    <= 1'b0;
            rd_addr_d <= '0;
            test_err  <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            rd_vld    <= (state == READ);
            rd_addr_d <= addr;
            if (mismatch) begin
                test_err <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_self_test.sv
// ----------------------------------------------------------------------------
// tb_ram_self_test
// Directed bench for ram_self_test. The full-size instance covers the reset
// state, the pass timing, the RAM pattern, the checker timing, and a reset
// in the middle of a pass. A second instance with a 16-deep RAM runs 256
// passes to exercise the wrap of pass_cnt within a short run.
// ----------------------------------------------------------------------------
module tb_ram_self_test;

`ifdef RAM_TEST_ERR_INJECT_EN
    localparam int EP = 1;
`else
    localparam int EP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_small;
    logic        test_done;
    logic        test_err;
    logic [15:0] err_cnt;
    logic [7:0]  pass_cnt;
    logic        s_done;
    logic        s_err;
    logic [15:0] s_err_cnt;
    logic [7:0]  s_pass_cnt;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int last_done = 0;

    ram_self_test dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_done (test_done),
        .test_err  (test_err),
        .err_cnt   (err_cnt),
        .pass_cnt  (pass_cnt)
    );

    ram_self_test #(
        .ADDR_W (4)
    ) dut_small (
        .clk       (clk),
        .rst_n     (rst_small),
        .test_done (s_done),
        .test_err  (s_err),
        .err_cnt   (s_err_cnt),
        .pass_cnt  (s_pass_cnt)
    );

    // 20 ns clock period
    initial forever #10 clk = ~clk;

    // Compares an observed value against the expected value and counts the
    // comparison.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advances to the falling edge of cycle 'target' and records test_done
    // pulses on the way. Cycle 0 is the IDLE cycle right after reset release.
    task automatic applyStimulus(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
            if (test_done) begin
                done_cnt++;
                last_done = cyc;
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        rst_small = 1'b1;

        // 100 ns of reset
        repeat (5) @(negedge clk);
        checkOutput("rst_done",     32'(test_done), 32'd0);
        checkOutput("rst_err",      32'(test_err),  32'd0);
        checkOutput("rst_err_cnt",  32'(err_cnt),   32'd0);
        checkOutput("rst_pass_cnt", 32'(pass_cnt),  32'd0);
        checkOutput("rst_we",       32'(dut.we),    32'd0);

        rst_n = 1'b0;
        cyc   = 0;

        // Pass 0: word 0 is written in cycle 1, word 5 in cycle 6,
        // word 511 in cycle 512
        applyStimulus(2);
        checkOutput("p0_mem0",   32'(dut.u_ram.mem[0]),   32'h0000);
        applyStimulus(7);
        checkOutput("p0_mem5",   32'(dut.u_ram.mem[5]),   32'h0005 ^ 32'(EP));
        applyStimulus(513);
        checkOutput("p0_mem1ff", 32'(dut.u_ram.mem[511]), 32'h01FF);

        // Address 5 is issued in READ cycle 518; the flag changes after cycle 519
        applyStimulus(519);
        checkOutput("err_before_a5", 32'(test_err), 32'd0);
        applyStimulus(520);
        checkOutput("err_after_a5",  32'(test_err), 32'(EP));
        checkOutput("cnt_after_a5",  32'(err_cnt),  32'(EP));

        applyStimulus(1026);
        checkOutput("p0_done_cnt",  32'(done_cnt),  32'd1);
        checkOutput("p0_done_cyc",  32'(last_done), 32'd1025);
        checkOutput("p0_pass_cnt",  32'(pass_cnt),  32'd1);
        checkOutput("p0_err_cnt",   32'(err_cnt),   32'(EP));
        checkOutput("p0_test_err",  32'(test_err),  32'(EP));

        // Pass 1 starts in cycle 1026
        applyStimulus(1028);
        checkOutput("p1_mem0",   32'(dut.u_ram.mem[0]),   32'h0100);
        applyStimulus(1539);
        checkOutput("p1_mem1ff", 32'(dut.u_ram.mem[511]), 32'h02FF);
        applyStimulus(2052);
        checkOutput("p1_done_cnt", 32'(done_cnt),  32'd2);
        checkOutput("p1_done_cyc", 32'(last_done), 32'd2051);
        checkOutput("p1_pass_cnt", 32'(pass_cnt),  32'd2);
        checkOutput("p1_err_cnt",  32'(err_cnt),   32'(2 * EP));

        // Pass 2 issues READ address 100 in cycle 2052 + 513 + 100
        applyStimulus(2665);
        checkOutput("mid_addr", 32'(dut.addr), 32'd100);
        #2 rst_n = 1'b1;
        #1;
        checkOutput("async_pass_cnt", 32'(pass_cnt),  32'd0);
        checkOutput("async_err_cnt",  32'(err_cnt),   32'd0);
        checkOutput("async_test_err", 32'(test_err),  32'd0);
        checkOutput("async_done",     32'(test_done), 32'd0);
        checkOutput("async_addr",     32'(dut.addr),  32'd0);

        repeat (3) @(negedge clk);
        rst_n     = 1'b0;
        cyc       = 0;
        done_cnt  = 0;
        last_done = 0;
        applyStimulus(1026);
        checkOutput("rr_done_cnt", 32'(done_cnt),  32'd1);
        checkOutput("rr_done_cyc", 32'(last_done), 32'd1025);
        checkOutput("rr_pass_cnt", 32'(pass_cnt),  32'd1);
        checkOutput("rr_err_cnt",  32'(err_cnt),   32'(EP));

        // Small instance: 34-cycle passes; pass n completes after cycle 34n-1
        checkOutput("small_rst_pass", 32'(s_pass_cnt), 32'd0);
        rst_small = 1'b0;
        repeat (34 * 255) @(negedge clk);
        checkOutput("small_pass255", 32'(s_pass_cnt), 32'd255);
        repeat (33) @(negedge clk);
        checkOutput("small_last_done", 32'(s_done),     32'd1);
        checkOutput("small_pre_wrap",  32'(s_pass_cnt), 32'd255);
        @(negedge clk);
        checkOutput("small_wrap",    32'(s_pass_cnt), 32'd0);
        checkOutput("small_err_cnt", 32'(s_err_cnt),  32'(256 * EP));
        checkOutput("small_err",     32'(s_err),      32'(EP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
